de_panel_io: RTL and testbench
==============================

// Module: de_panel_io
// PURPOSE
//  Parametrised front-panel I/O engine for DE-series top levels. Replaces the
//  hard-tied HEX/LED assigns with live logic: it synchronises and debounces the
//  KEY and SW inputs, emits key press/release pulses, and drives NUM_HEX
//  registered 7-segment digits with per-digit blank and blink. It sits directly
//  under the board top level, between the pins and user logic.
// PARAMETERS
//  NUM_KEYS      4           pushbutton channels
//  NUM_SW        10          toggle-switch channels
//  NUM_HEX       4           7-segment digits
//  DB_CYCLES     500000      debounce stable time in clocks (10 ms @ 50 MHz); must be >= 2
//  BLINK_CYCLES  12500000    clocks per blink half-period; must be >= 1
//  KEY_ACT_LOW   1           1: KEY pin low = pressed
//  SEG_ACT_LOW   1           1: segment bit 0 = lit
// PORTS
//  CLOCK_50    in   1           system clock
//  RESET       in   1           asynchronous reset, active high
//  KEY         in   NUM_KEYS    raw pushbutton pins
//  SW          in   NUM_SW      raw switch pins
//  key_level   out  NUM_KEYS    debounced state, 1 = pressed
//  key_press   out  NUM_KEYS    1-clock pulse on debounced press
//  key_release out  NUM_KEYS    1-clock pulse on debounced release
//  sw_level    out  NUM_SW      debounced switch state
//  hex_value   in   4*NUM_HEX   nibble per digit; digit i = [4i+3:4i]
//  hex_blank   in   NUM_HEX     1 = digit dark
//  hex_blink   in   NUM_HEX     1 = digit flashes at the blink rate
//  HEX_SEG     out  7*NUM_HEX   segments per digit; digit i = [7i+6:7i], bit0=a .. bit6=g
// BEHAVIOUR
//  Reset (async on RESET rise, held while high):
//   - key sync FFs = released level; switch sync FFs = 0.
//   - key_level = 0, sw_level = 0, key_press = key_release = 0.
//   - debounce counters = 0, blink counter = 0, blink phase = 0.
//   - HEX_SEG = all segments off.
//  Input path, per channel:
//   - 2-FF synchroniser, then debounce channel holding `stable` and counter `cnt`.
//   - sync == stable: cnt <= 0.
//   - sync != stable and cnt < DB_CYCLES-1: cnt <= cnt+1.
//   - sync != stable and cnt == DB_CYCLES-1: stable <= sync, cnt <= 0.
//   - Latency: a clean edge reaches key_level/sw_level 2+DB_CYCLES clocks after it hits the pin.
//   - A glitch of fewer than DB_CYCLES synchronised clocks never changes stable.
//   - A bounce restarts the count from 0.
//  Press/release pulses:
//   - key_press[i] = 1 for the single clock after key_level[i] goes 0->1.
//   - key_release[i] is the same for 1->0.
//   - Pulses are registered.
//   - Channels are independent; simultaneous presses give simultaneous pulses.
//   - No pulses at reset exit: the sync FFs are preset to the released level.
//   - Switches have no pulses. A switch that is high at reset exit reaches
//     sw_level 2+DB_CYCLES clocks later.
//  Blink:
//   - Free-running counter 0..BLINK_CYCLES-1; phase toggles on wrap.
//   - The blink timebase is shared by all digits.
//  Display, registered, 1-clock latency from hex_value/hex_blank/hex_blink:
//   - off = hex_blank[i] | (hex_blink[i] & phase).
//   - off: all 7 segments unlit.
//   - else: standard 0-F glyph.
//   - Polarity is inverted when SEG_ACT_LOW=1.
//  Counter widths: $clog2 of the limit; no counter ever exceeds its limit.
//  Reset mid-debounce discards the pending edge; the channel re-qualifies after reset.
// STRUCTURE
//  Package de_panel_pkg:
//   - seg7 glyph function (nibble -> 7 bits, active-high, a..g).
//   - SEG_OFF constant.
//  Sub-module debounce_ch (param DB_CYCLES, RST_VAL):
//   - one synchroniser + debounce channel.
//   - generate-instantiated NUM_KEYS+NUM_SW times.
//  Top: edge-pulse registers, blink timebase, per-digit output registers.
// TESTING (bench: DB_CYCLES=8, BLINK_CYCLES=4, defaults otherwise)
//  1. Reset:
//     - stimulus: RESET high, KEY=4'hF.
//     - expect: key_level=0, pulses=0, every HEX_SEG digit=7'h7F.
//     - RESET low, hold 20 clk -> still no pulses.
//  2. Clean press:
//     - stimulus: KEY[0] 1->0, held.
//     - expect: key_level[0]=1 exactly 10 clk later; key_press[0] one clk wide.
//     - release -> key_release[0] pulse 10 clk after release.
//  3. Bounce:
//     - stimulus: KEY[1] low 5 clk, high 2, low 5, high.
//     - expect: key_level[1] stays 0, no pulse.
//     - stimulus: low 12 clk.
//     - expect: exactly one press pulse.
//  4. Simultaneous:
//     - stimulus: KEY[3:2] drop together.
//     - expect: key_press[3:2]=2'b11 on the same clk.
//     - stimulus: SW=10'h2A5.
//     - expect: sw_level=10'h2A5 after 10 clk.
//  5. Display:
//     - stimulus: hex_value=16'h80F1, blank=0.
//     - expect 1 clk later: digit0=7'h79, digit1=7'h0E, digit2=7'h40, digit3=7'h00.
//     - stimulus: blank[2]=1.
//     - expect: digit2=7'h7F.
//  6. Blink/reset:
//     - stimulus: blink[0]=1.
//     - expect: digit0 toggles glyph/7'h7F every 4 clk.
//     - stimulus: RESET asserted mid-debounce of KEY[0].
//     - expect: all outputs return to reset values at once, no pulse after release.

Source files
------------

// File: rtl/de_panel_pkg.sv
// rtl/de_panel_pkg.sv - shared glyph table and segment constants for the panel I/O engine
package de_panel_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Active-high glyphs, bit0 = a .. bit6 = g
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0:    seg7 = 7'h3F;
            4'h1:    seg7 = 7'h06;
            4'h2:    seg7 = 7'h5B;
            4'h3:    seg7 = 7'h4F;
            4'h4:    seg7 = 7'h66;
            4'h5:    seg7 = 7'h6D;
            4'h6:    seg7 = 7'h7D;
            4'h7:    seg7 = 7'h07;
            4'h8:    seg7 = 7'h7F;
            4'h9:    seg7 = 7'h6F;
            4'hA:    seg7 = 7'h77;
            4'hB:    seg7 = 7'h7C;
            4'hC:    seg7 = 7'h39;
            4'hD:    seg7 = 7'h5E;
            4'hE:    seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

endpackage

// File: rtl/de_panel_io_debounce_ch.sv
// rtl/de_panel_io_debounce_ch.sv - one 2-FF synchroniser plus stable-time debounce channel
module debounce_ch #(
    parameter int   DB_CYCLES = 500000,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable
);

    localparam int             CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Any disagreement that does not persist for DB_CYCLES samples restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= RST_VAL;
            sync2  <= RST_VAL;
            stable <= RST_VAL;
            cnt    <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/de_panel_io.sv
// rtl/de_panel_io.sv - debounced keys/switches with press/release pulses and blinking 7-segment drive
module de_panel_io
    import de_panel_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter int NUM_SW       = 10,
    parameter int NUM_HEX      = 4,
    parameter int DB_CYCLES    = 500000,
    parameter int BLINK_CYCLES = 12500000,
    parameter int KEY_ACT_LOW  = 1,
    parameter int SEG_ACT_LOW  = 1
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET,
    input  logic [NUM_KEYS-1:0]    KEY,
    input  logic [NUM_SW-1:0]      SW,
    output logic [NUM_KEYS-1:0]    key_level,
    output logic [NUM_KEYS-1:0]    key_press,
    output logic [NUM_KEYS-1:0]    key_release,
    output logic [NUM_SW-1:0]      sw_level,
    input  logic [4*NUM_HEX-1:0]   hex_value,
    input  logic [NUM_HEX-1:0]     hex_blank,
    input  logic [NUM_HEX-1:0]     hex_blink,
    output logic [7*NUM_HEX-1:0]   HEX_SEG
);

    localparam logic               KEY_REL   = (KEY_ACT_LOW != 0);
    localparam logic [6:0]         SEG_POL   = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam int                 BLINK_W   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [NUM_KEYS-1:0] key_stable;
    logic [NUM_KEYS-1:0] key_prev;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                phase;
    logic [NUM_HEX-1:0]  digit_off;

    // Key channels debounce the raw pin level; their sync FFs preset to "released"
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        debounce_ch #(.DB_CYCLES(DB_CYCLES), .RST_VAL(KEY_REL)) u_ch (
            .clk    (CLOCK_50),
            .rst    (RESET),
            .din    (KEY[k]),
            .stable (key_stable[k])
        );
    end

    for (genvar s = 0; s < NUM_SW; s++) begin : g_sw
        debounce_ch #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_ch (
            .clk    (CLOCK_50),
            .rst    (RESET),
            .din    (SW[s]),
            .stable (sw_level[s])
        );
    end

    assign key_level = key_stable ^ {NUM_KEYS{KEY_REL}};

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            key_prev    <= '0;
            key_press   <= '0;
            key_release <= '0;
        end else begin
            key_prev    <= key_level;
            key_press   <= key_level & ~key_prev;
            key_release <= ~key_level & key_prev;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        digit_off = hex_blank | (hex_blink & {NUM_HEX{phase}});
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            HEX_SEG <= {NUM_HEX{SEG_OFF ^ SEG_POL}};
        end else begin
            for (int i = 0; i < NUM_HEX; i++) begin
                HEX_SEG[7*i +: 7] <= digit_off[i] ? (SEG_OFF ^ SEG_POL)
                                                  : (seg7(hex_value[4*i +: 4]) ^ SEG_POL);
            end
        end
    end

endmodule

// File: tb/tb_de_panel_io.sv
// tb/tb_de_panel_io.sv - self-checking bench for de_panel_io with a window-based reference model
module tb_de_panel_io;

    localparam int DB = 8;
    localparam int BL = 4;
    localparam int NK = 4;
    localparam int NS = 10;
    localparam int NC = NK + NS;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  key = 4'hF;
    logic [9:0]  sw = '0;
    logic [15:0] hv = '0;
    logic [3:0]  hb = '0;
    logic [3:0]  hk = '0;
    logic [3:0]  key_level, key_press, key_release;
    logic [9:0]  sw_level;
    logic [27:0] hex_seg;

    de_panel_io #(.DB_CYCLES(DB), .BLINK_CYCLES(BL)) dut (
        .CLOCK_50    (clk),
        .RESET       (rst),
        .KEY         (key),
        .SW          (sw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .sw_level    (sw_level),
        .hex_value   (hv),
        .hex_blank   (hb),
        .hex_blink   (hk),
        .HEX_SEG     (hex_seg)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    bit [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: a channel adopts the opposite level once its last DB
    // synchronised samples (pin delayed 2 clocks) all disagree with it.
    bit          hist [NC][64];
    int          last_flip [NC];
    bit          stab [NC];
    bit [3:0]    prevl;
    int          n = 0;
    int          t_blink = 0;
    logic [3:0]  exp_kl, exp_press, exp_rel;
    logic [9:0]  exp_sw;
    logic [27:0] exp_hex;
    int          press_seen [4];
    int          rel_seen [4];
    logic [3:0]  kl_seen;

    function automatic bit pin_of(int c);
        return (c < NK) ? key[c] : sw[c-NK];
    endfunction

    task automatic model_step();
        bit flip;
        bit lv;
        int phase;
        n++;
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                stab[c] = (c < NK);
                hist[c][n%64] = (c < NK);
                hist[c][(n+63)%64] = (c < NK);
                last_flip[c] = n;
            end
            prevl = '0; exp_press = '0; exp_rel = '0;
            t_blink = 0;
            exp_hex = {4{7'h7F}};
        end else begin
            t_blink++;
            for (int c = 0; c < NC; c++) begin
                hist[c][n%64] = pin_of(c);
                if (c < NK) begin
                    lv = ~stab[c];
                    exp_press[c] = lv & ~prevl[c];
                    exp_rel[c] = ~lv & prevl[c];
                    prevl[c] = lv;
                end
                flip = (n - DB + 1 > last_flip[c]);
                if (flip)
                    for (int k = n - DB + 1; k <= n; k++)
                        if (hist[c][(k-2)%64] == stab[c]) flip = 0;
                if (flip) begin
                    stab[c] = hist[c][(n-2)%64];
                    last_flip[c] = n;
                end
            end
            phase = ((t_blink - 1) / BL) % 2;
            for (int d = 0; d < 4; d++)
                exp_hex[7*d +: 7] = (hb[d] | (hk[d] & (phase == 1))) ? 7'h7F : ~glyph[hv[4*d +: 4]];
        end
        for (int c = 0; c < NK; c++) exp_kl[c] = ~stab[c];
        for (int c = 0; c < NS; c++) exp_sw[c] = stab[NK + c];
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_keys", {20'd0, key_level, key_press, key_release}, {20'd0, exp_kl, exp_press, exp_rel});
        chk("model_sw", {22'd0, sw_level}, {22'd0, exp_sw});
        chk("model_hex", {4'd0, hex_seg}, {4'd0, exp_hex});
        for (int i = 0; i < 4; i++) begin
            press_seen[i] += int'(key_press[i]);
            rel_seen[i] += int'(key_release[i]);
        end
        kl_seen |= key_level;
    endtask

    task automatic ticks(input int cnt);
        for (int i = 0; i < cnt; i++) tick();
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 4; i++) begin
            press_seen[i] = 0;
            rel_seen[i] = 0;
        end
        kl_seen = '0;
    endtask

    typedef struct {
        logic [15:0] value;
        logic [3:0]  blank;
        logic [27:0] segs;
    } disp_vec_t;

    disp_vec_t dv [7];

    initial begin
        int found, press_at, rel_at, hold [NC];
        logic [6:0] s [16];
        int k0;

        dv[0] = '{16'h80F1, 4'b0000, {7'h00, 7'h40, 7'h0E, 7'h79}};
        dv[1] = '{16'h80F1, 4'b0100, {7'h00, 7'h7F, 7'h0E, 7'h79}};
        dv[2] = '{16'h2345, 4'b0000, {7'h24, 7'h30, 7'h19, 7'h12}};
        dv[3] = '{16'h6789, 4'b0000, {7'h02, 7'h78, 7'h00, 7'h10}};
        dv[4] = '{16'hABCD, 4'b0000, {7'h08, 7'h03, 7'h46, 7'h21}};
        dv[5] = '{16'hEF00, 4'b1111, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
        dv[6] = '{16'hE000, 4'b0001, {7'h06, 7'h40, 7'h40, 7'h7F}};

        // 1. reset
        #1 rst = 1'b1;
        #1;
        chk("rst_key_level", {28'd0, key_level}, 32'd0);
        chk("rst_pulses", {24'd0, key_press, key_release}, 32'd0);
        chk("rst_hex", {4'd0, hex_seg}, {4'd0, 28'hFFFFFFF});
        chk("rst_sw", {22'd0, sw_level}, 32'd0);
        ticks(3);
        rst = 1'b0;
        clear_seen();
        ticks(20);
        chk("rst_exit_pulses", press_seen[0] + press_seen[1] + press_seen[2] + press_seen[3]
                               + rel_seen[0] + rel_seen[1] + rel_seen[2] + rel_seen[3], 32'd0);

        // 2. clean press and release
        key[0] = 1'b0;
        found = 0; press_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (found == 0 && key_level[0]) found = i;
            if (press_at == 0 && key_press[0]) press_at = i;
        end
        chk("press_latency", found, 10);
        chk("press_pulse_at", press_at, 11);
        chk("press_pulse_cnt", press_seen[0], 1);
        key[0] = 1'b1;
        rel_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (rel_at == 0 && key_release[0]) rel_at = i;
        end
        chk("release_pulse_at", rel_at, 11);

        // 3. bounce
        clear_seen();
        key[1] = 1'b0; ticks(5);
        key[1] = 1'b1; ticks(2);
        key[1] = 1'b0; ticks(5);
        key[1] = 1'b1; ticks(20);
        chk("bounce_level", {31'd0, kl_seen[1]}, 32'd0);
        chk("bounce_press", press_seen[1], 0);
        clear_seen();
        key[1] = 1'b0; ticks(12);
        ticks(8);
        chk("bounce_settle_press", press_seen[1], 1);
        key[1] = 1'b1; ticks(20);

        // 4. simultaneous keys and switches
        key[3:2] = 2'b00;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (key_press[3:2] != 2'b00) begin
                found = 1;
                chk("simul_press", {30'd0, key_press[3:2]}, 32'd3);
            end
        end
        chk("simul_seen", found, 1);
        sw = 10'h2A5;
        ticks(9);
        chk("sw_before", {22'd0, sw_level}, 32'd0);
        ticks(1);
        chk("sw_after", {22'd0, sw_level}, 32'h2A5);
        key[3:2] = 2'b11;
        ticks(20);

        // 5. display table
        for (int i = 0; i < 7; i++) begin
            hv = dv[i].value;
            hb = dv[i].blank;
            hk = '0;
            tick();
            chk($sformatf("disp_vec%0d", i), {4'd0, hex_seg}, {4'd0, dv[i].segs});
        end

        // 6. blink then reset mid-debounce
        hv = 16'h0001; hb = '0; hk = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            tick();
            s[i] = hex_seg[6:0];
        end
        k0 = 0;
        for (int i = 4; i >= 1; i--) if (s[i] != s[i-1]) k0 = i;
        chk("blink_first_toggle", {31'd0, k0 != 0}, 32'd1);
        if (k0 != 0) begin
            chk("blink_pair", {18'd0, s[k0] ^ s[k0-1], s[k0] & s[k0-1]}, {18'd0, 7'h06, 7'h79});
            for (int j = k0; j < k0 + 11; j++)
                chk($sformatf("blink_t%0d", j), {25'd0, s[j]}, {25'd0, (((j - k0) / 4) % 2 == 0) ? s[k0] : s[k0-1]});
        end
        hk = '0;
        key[0] = 1'b0;
        ticks(5);
        rst = 1'b1;
        #1;
        chk("midrst_keys", {20'd0, key_level, key_press, key_release}, 32'd0);
        chk("midrst_sw", {22'd0, sw_level}, 32'd0);
        chk("midrst_hex", {4'd0, hex_seg}, {4'd0, 28'hFFFFFFF});
        key[0] = 1'b1;
        ticks(3);
        rst = 1'b0;
        clear_seen();
        ticks(20);
        chk("midrst_no_pulse", press_seen[0] + rel_seen[0], 0);

        // randomized run against the model
        for (int c = 0; c < NC; c++) hold[c] = 0;
        for (int t = 0; t < 2000; t++) begin
            for (int c = 0; c < NC; c++) begin
                if (hold[c] == 0) begin
                    if (c < NK) key[c] = 1'($urandom_range(0, 1));
                    else sw[c-NK] = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 14);
                end
                hold[c]--;
            end
            if (t % 8 == 0) begin
                hv = 16'($urandom);
                hb = 4'($urandom);
                hk = 4'($urandom);
            end
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        ticks(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
